// File: rtl/spi_mnrch_16.sv
// spi_mnrch_16: 16-bit SPI master, SCLK = clk/16 idling high, MOSI launched and MISO shifted in on SCLK falls.
module spi_mnrch_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);
  typedef enum logic [1:0] {IDLE, FRONT, SHIFT, BACK} state_t;
  state_t r_state, w_nxt;
  logic [3:0]  r_div;
  logic [15:0] r_shreg;
  logic [4:0]  r_bit_cnt;
  logic        r_smpl, r_ss_n, r_done;
  logic        w_start, w_rise, w_fall, w_shift, w_last;
  assign w_start = r_state == IDLE && wrt;
  assign w_rise  = r_div == 4'b0111;
  assign w_fall  = r_div == 4'b1111;
  assign w_shift = r_state == SHIFT && w_fall;
  assign w_last  = w_shift && r_bit_cnt == 5'd15;
  assign SCLK    = r_div[3];
  assign MOSI    = r_shreg[15];
  assign rd_data = r_shreg;
  assign SS_n    = r_ss_n;
  assign done    = r_done;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  always_comb begin
    w_nxt = r_state;
    w_nxt = r_state == IDLE  ? (wrt ? FRONT : IDLE) :
            r_state == FRONT ? (w_fall ? SHIFT : FRONT) :
            r_state == SHIFT ? (w_last ? BACK : SHIFT) : IDLE;
  end
  // the final shift parks div at 1111 so SCLK stays high with no 17th fall
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_div     <= 4'b1111;
      r_shreg   <= 16'h0000;
      r_bit_cnt <= 5'd0;
      r_smpl    <= 1'b0;
      r_ss_n    <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_div <= w_start ? 4'b1011 :
               (r_state == IDLE || r_state == BACK || w_last) ? 4'b1111 : r_div + 4'd1;
      if (w_start) begin
        r_shreg   <= cmd;
        r_bit_cnt <= 5'd0;
        r_ss_n    <= 1'b0;
        r_done    <= 1'b0;
      end
      if (r_state == SHIFT && w_rise) r_smpl <= MISO;
      if (w_shift) begin
        r_shreg   <= {r_shreg[14:0], r_smpl};
        r_bit_cnt <= r_bit_cnt + 5'd1;
      end
      if (r_state == BACK) begin
        r_ss_n <= 1'b1;
        r_done <= 1'b1;
      end
    end
endmodule
